// File: rtl/streebog_pkg.sv
// rtl/streebog_pkg.sv - shared types, constants and padding helper for the Streebog controller
package streebog_pkg;

  localparam int                 LEN_W    = 10;
  localparam logic [LEN_W-1:0]   FULL_LEN = 10'd512;
  localparam logic [511:0]       IV_512   = '0;
  localparam logic [511:0]       IV_256   = {64{8'h01}};

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_BLK = 3'd1,
    G_MSG    = 3'd2,
    PAD      = 3'd3,
    G_N      = 3'd4,
    G_SIGMA  = 3'd5
  } state_t;

  // Saturate an out-of-range length to a full block.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    clamp_len = (len > FULL_LEN) ? FULL_LEN : len;
  endfunction

  // Keep the low len message bits and place the single pad bit directly above them.
  function automatic logic [511:0] pad_block(input logic [511:0] data, input logic [LEN_W-1:0] len);
    logic [511:0] marker;
    marker = 512'd1 << len;
    if (len >= FULL_LEN) pad_block = data;
    else                 pad_block = (data & (marker - 512'd1)) | marker;
  endfunction

endpackage

// File: rtl/streebog_add512.sv
// rtl/streebog_add512.sv - registered modular adder shared by the N and Sigma updates
module streebog_add512
  import streebog_pkg::*;
#(
  parameter int W = 512
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o
);

  // Sum wraps naturally at W bits; one cycle of latency.
  always_ff @(posedge clk_i) begin
    if (rst_i) sum_o <= '0;
    else       sum_o <= a_i + b_i;
  end

endmodule

// File: rtl/streebog_ctrl.sv
// rtl/streebog_ctrl.sv - message-side sequencer driving one g_function instance
module streebog_ctrl
  import streebog_pkg::*;
#(
  parameter int DATA_WIDTH = 512
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  mode256_i,
  input  logic                  blk_valid_i,
  output logic                  blk_ready_o,
  input  logic [DATA_WIDTH-1:0] blk_data_i,
  input  logic                  blk_last_i,
  input  logic [LEN_W-1:0]      blk_len_i,
  output logic                  g_valid_o,
  output logic [DATA_WIDTH-1:0] g_n_o,
  output logic [DATA_WIDTH-1:0] g_m_o,
  output logic [DATA_WIDTH-1:0] g_h_o,
  input  logic [DATA_WIDTH-1:0] g_hash_i,
  input  logic                  g_hash_valid_i,
  output logic [DATA_WIDTH-1:0] hash_o,
  output logic                  hash_valid_o,
  output logic                  busy_o
);

  state_t                  state, state_nxt;
  logic                    mode256_q;
  logic [DATA_WIDTH-1:0]   h_q, n_q, sigma_q, n_sum_q;
  logic [LEN_W-1:0]        len_c, len_q, add_len;
  logic                    last_q;
  logic                    accept, result_ok;
  logic                    add_n_sel, add_n_sel_q;
  logic [DATA_WIDTH-1:0]   add_a, add_b, add_sum;

  assign len_c     = clamp_len(blk_len_i);
  assign accept    = (state == WAIT_BLK) && blk_valid_i;
  assign result_ok = g_hash_valid_i && ((state == G_MSG) || (state == G_N) || (state == G_SIGMA));

  // The adder computes N+len in the cycle a message round is loaded, then
  // Sigma+m for the rest of the round; both are ready before g_function answers.
  assign add_n_sel = accept || (state == PAD);
  assign add_len   = (state == PAD) ? '0 : len_c;
  assign add_a     = add_n_sel ? n_q : sigma_q;
  assign add_b     = add_n_sel ? {{(DATA_WIDTH-LEN_W){1'b0}}, add_len} : g_m_o;

  streebog_add512 #(.W(DATA_WIDTH)) u_add (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .a_i   (add_a),
    .b_i   (add_b),
    .sum_o (add_sum)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; a last full block needs an extra all-padding round.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start_i) state_nxt = WAIT_BLK;
      WAIT_BLK: if (accept)  state_nxt = G_MSG;
      G_MSG: begin
        if (result_ok) begin
          if (!last_q)                state_nxt = WAIT_BLK;
          else if (len_q == FULL_LEN) state_nxt = PAD;
          else                        state_nxt = G_N;
        end
      end
      PAD:      state_nxt = G_MSG;
      G_N:      if (result_ok) state_nxt = G_SIGMA;
      G_SIGMA:  if (result_ok) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state.
  always_comb begin
    blk_ready_o = 1'b0;
    busy_o      = 1'b0;
    if (state == WAIT_BLK) blk_ready_o = 1'b1;
    if (state != IDLE)     busy_o      = 1'b1;
  end

  // Chaining state, request operands and digest; operands are loaded one
  // cycle before the request pulse and held until the answer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode256_q    <= 1'b0;
      h_q          <= '0;
      n_q          <= '0;
      sigma_q      <= '0;
      n_sum_q      <= '0;
      len_q        <= '0;
      last_q       <= 1'b0;
      add_n_sel_q  <= 1'b0;
      g_valid_o    <= 1'b0;
      g_n_o        <= '0;
      g_m_o        <= '0;
      g_h_o        <= '0;
      hash_o       <= '0;
      hash_valid_o <= 1'b0;
    end else begin
      g_valid_o    <= 1'b0;
      hash_valid_o <= 1'b0;
      add_n_sel_q  <= add_n_sel;
      if (add_n_sel_q) n_sum_q <= add_sum;
      case (state)
        IDLE: begin
          if (start_i) begin
            mode256_q <= mode256_i;
            h_q       <= mode256_i ? IV_256 : IV_512;
            n_q       <= '0;
            sigma_q   <= '0;
          end
        end
        WAIT_BLK: begin
          if (accept) begin
            g_h_o     <= h_q;
            g_n_o     <= n_q;
            g_m_o     <= pad_block(blk_data_i, len_c);
            len_q     <= len_c;
            last_q    <= blk_last_i;
            g_valid_o <= 1'b1;
          end
        end
        G_MSG: begin
          if (result_ok) begin
            h_q     <= g_hash_i;
            n_q     <= n_sum_q;
            sigma_q <= add_sum;
            if (last_q && (len_q != FULL_LEN)) begin
              g_h_o     <= g_hash_i;
              g_n_o     <= '0;
              g_m_o     <= n_sum_q;
              g_valid_o <= 1'b1;
            end
          end
        end
        PAD: begin
          g_h_o     <= h_q;
          g_n_o     <= n_q;
          g_m_o     <= {{(DATA_WIDTH-1){1'b0}}, 1'b1};
          len_q     <= '0;
          g_valid_o <= 1'b1;
        end
        G_N: begin
          if (result_ok) begin
            h_q       <= g_hash_i;
            g_h_o     <= g_hash_i;
            g_n_o     <= '0;
            g_m_o     <= sigma_q;
            g_valid_o <= 1'b1;
          end
        end
        G_SIGMA: begin
          if (result_ok) begin
            h_q          <= g_hash_i;
            hash_o       <= mode256_q ? {g_hash_i[DATA_WIDTH-1:DATA_WIDTH/2], {(DATA_WIDTH/2){1'b0}}}
                                      : g_hash_i;
            hash_valid_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_streebog_ctrl.sv
// tb/tb_streebog_ctrl.sv - scoreboard bench for streebog_ctrl with a stand-in compression function
module tb_streebog_ctrl;

  localparam int TMO = 2000;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         start_i = 1'b0, mode256_i = 1'b0;
  logic         blk_valid_i = 1'b0, blk_last_i = 1'b0;
  logic         blk_ready_o;
  logic [511:0] blk_data_i = '0;
  logic [9:0]   blk_len_i = '0;
  logic         g_valid_o;
  logic [511:0] g_n_o, g_m_o, g_h_o;
  logic [511:0] g_hash_i = '0;
  logic         g_hash_valid_i = 1'b0;
  logic [511:0] hash_o;
  logic         hash_valid_o, busy_o;

  typedef struct { logic [511:0] n; logic [511:0] h; logic [511:0] m; } req_t;
  typedef struct { logic [511:0] d; logic [9:0] len; logic last; } blk_t;

  req_t         exp_req_q[$];
  logic [511:0] exp_hash_q[$];
  req_t         log_q[$];
  blk_t         msg[$];

  int errors = 0, checks = 0;
  int pulse_cnt = 0, lat = 1, inj_req = 0, inj_done = 0;
  logic         pend = 1'b0;
  int           cnt = 0;
  logic [511:0] pend_res = '0;

  always #5 clk = ~clk;

  streebog_ctrl #(.DATA_WIDTH(512)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .mode256_i(mode256_i),
    .blk_valid_i(blk_valid_i), .blk_ready_o(blk_ready_o), .blk_data_i(blk_data_i),
    .blk_last_i(blk_last_i), .blk_len_i(blk_len_i),
    .g_valid_o(g_valid_o), .g_n_o(g_n_o), .g_m_o(g_m_o), .g_h_o(g_h_o),
    .g_hash_i(g_hash_i), .g_hash_valid_i(g_hash_valid_i),
    .hash_o(hash_o), .hash_valid_o(hash_valid_o), .busy_o(busy_o)
  );

  // Stand-in compression function: depends on every operand so misrouting shows.
  function automatic logic [511:0] gf(input logic [511:0] n, input logic [511:0] h, input logic [511:0] m);
    logic [511:0] hr, nr;
    hr = {h[502:0], h[511:503]} ^ {8{64'h9e3779b97f4a7c15}};
    nr = {n[510:0], n[511]};
    return (hr + m) ^ nr;
  endfunction

  function automatic blk_t mk(input logic [511:0] d, input logic [9:0] len, input logic last);
    blk_t b;
    b.d = d; b.len = len; b.last = last;
    return b;
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_chk(input string name, input int n);
    checks++;
    if (n >= TMO) begin
      errors++;
      $display("FAIL %s: timeout after %0d cycles", name, n);
    end
  endtask

  task automatic push_req(input logic [511:0] n, input logic [511:0] h, input logic [511:0] m,
                          inout int nreq, input int max_req);
    req_t r;
    r.n = n; r.h = h; r.m = m;
    if (nreq < max_req) exp_req_q.push_back(r);
    nreq++;
  endtask

  // Reference iteration over the module-level msg queue.
  task automatic model(input bit m256, input int max_req);
    logic [511:0] h, nn, s, m;
    int L, nreq;
    nreq = 0;
    h = m256 ? {64{8'h01}} : 512'd0;
    nn = '0; s = '0;
    foreach (msg[k]) begin
      L = (msg[k].len > 10'd512) ? 512 : int'(msg[k].len);
      for (int i = 0; i < 512; i++) m[i] = (i < L) ? msg[k].d[i] : (i == L);
      push_req(nn, h, m, nreq, max_req);
      h = gf(nn, h, m);
      nn = nn + 512'(L);
      s = s + m;
      if (msg[k].last && L == 512) begin
        push_req(nn, h, 512'd1, nreq, max_req);
        h = gf(nn, h, 512'd1);
        s = s + 512'd1;
      end
    end
    push_req(512'd0, h, nn, nreq, max_req);
    h = gf(512'd0, h, nn);
    push_req(512'd0, h, s, nreq, max_req);
    h = gf(512'd0, h, s);
    if (nreq <= max_req) exp_hash_q.push_back(m256 ? {h[511:256], 256'd0} : h);
  endtask

  // g_function stand-in: checks each request against the scoreboard, answers after lat cycles.
  always @(negedge clk) begin
    req_t e, r;
    if (g_hash_valid_i) g_hash_valid_i = 1'b0;
    else if (pend && busy_o) begin
      if (cnt == 0) begin g_hash_i = pend_res; g_hash_valid_i = 1'b1; pend = 1'b0; end
      else cnt--;
    end else if (inj_req != inj_done) begin
      g_hash_i = {16{32'h5a5aa5a5}};
      g_hash_valid_i = 1'b1;
      inj_done++;
    end
    if (!busy_o) pend = 1'b0;
    if (g_valid_o && !rst_i) begin
      r.n = g_n_o; r.h = g_h_o; r.m = g_m_o;
      log_q.push_back(r);
      pulse_cnt++;
      checks++;
      if (pend) begin
        errors++;
        $display("FAIL req_overlap: got request while one outstanding");
      end
      if (exp_req_q.size() == 0) begin
        errors++;
        $display("FAIL req_unexpected: got m=%h", g_m_o);
      end else begin
        e = exp_req_q.pop_front();
        chk("req_n", g_n_o, e.n);
        chk("req_h", g_h_o, e.h);
        chk("req_m", g_m_o, e.m);
      end
      pend_res = gf(g_n_o, g_h_o, g_m_o);
      pend = 1'b1;
      cnt = lat;
    end
  end

  // Digest monitor.
  always @(negedge clk) begin
    if (!rst_i && hash_valid_o) begin
      if (exp_hash_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL hash_unexpected: got %h", hash_o);
      end else begin
        chk("digest", hash_o, exp_hash_q.pop_front());
      end
    end
  end

  task automatic start_hash(input bit m256);
    start_i = 1'b1; mode256_i = m256;
    @(negedge clk);
    start_i = 1'b0; mode256_i = ~m256;
  endtask

  task automatic send_block(input blk_t b);
    int n;
    blk_data_i = b.d; blk_len_i = b.len; blk_last_i = b.last; blk_valid_i = 1'b1;
    n = 0;
    while (!blk_ready_o && n < TMO) begin @(negedge clk); n++; end
    timeout_chk("blk_accept", n);
    @(negedge clk);
    blk_valid_i = 1'b0;
    blk_data_i = {16{32'hbad0bad0}};
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_o && n < TMO) begin @(negedge clk); n++; end
    timeout_chk("wait_idle", n);
    @(negedge clk);
  endtask

  task automatic run_msg(input bit m256);
    start_hash(m256);
    foreach (msg[k]) send_block(msg[k]);
    wait_idle();
  endtask

  initial begin
    int base, n;
    repeat (3) @(negedge clk);
    chk("rst_ready", 512'(blk_ready_o), 512'd0);
    chk("rst_busy", 512'(busy_o), 512'd0);
    chk("rst_gvalid", 512'(g_valid_o), 512'd0);
    chk("rst_hvalid", 512'(hash_valid_o), 512'd0);
    chk("rst_hash", hash_o, 512'd0);
    chk("rst_ops", g_n_o | g_m_o | g_h_o, 512'd0);
    rst_i = 1'b0;
    @(negedge clk);

    // Empty message, upper data bits ignored.
    lat = 1;
    msg.delete(); msg.push_back(mk({16{32'hdeadbeef}}, 10'd0, 1'b1));
    model(1'b0, 99); run_msg(1'b0);

    // 504-bit message in both digest sizes.
    lat = 0;
    msg.delete(); msg.push_back(mk({8'hab, {21{24'h313233}}}, 10'd504, 1'b1));
    model(1'b0, 99); run_msg(1'b0);
    lat = 2;
    model(1'b1, 99); run_msg(1'b1);

    // Single full last block: msg, PAD, N, Sigma requests.
    msg.delete(); msg.push_back(mk({8{64'h0f1e2d3c4b5a6978}}, 10'd512, 1'b1));
    model(1'b0, 99);
    base = pulse_cnt; log_q.delete();
    run_msg(1'b0);
    chk("full_pulses", 512'(pulse_cnt - base), 512'd4);
    if (log_q.size() >= 3) begin
      chk("pad_m", log_q[1].m, 512'd1);
      chk("gn_m", log_q[2].m, 512'd512);
      chk("gn_n", log_q[2].n, 512'd0);
    end else begin
      chk("full_log_size", 512'(log_q.size()), 512'd4);
    end

    // Multi-block: clamped length, Sigma wrap.
    lat = 0;
    msg.delete();
    msg.push_back(mk({512{1'b1}}, 10'd700, 1'b0));
    msg.push_back(mk({512{1'b1}}, 10'd512, 1'b0));
    msg.push_back(mk({16{32'h89abcdef}}, 10'd100, 1'b1));
    model(1'b1, 99); run_msg(1'b1);

    // Handshake, spurious result in WAIT_BLK, valid held during G_MSG.
    lat = 3;
    msg.delete();
    msg.push_back(mk({8{64'h1122334455667788}}, 10'd512, 1'b0));
    msg.push_back(mk({8{64'h99aabbccddeeff00}}, 10'd512, 1'b0));
    msg.push_back(mk({16{32'h0badf00d}}, 10'd300, 1'b1));
    model(1'b0, 99);
    start_hash(1'b0);
    send_block(msg[0]);
    chk("gmsg_not_ready", 512'(blk_ready_o), 512'd0);
    n = 0;
    while (!blk_ready_o && n < TMO) begin @(negedge clk); n++; end
    timeout_chk("ready_again", n);
    inj_req++;
    repeat (3) @(negedge clk);
    chk("inject_busy", 512'(busy_o), 512'd1);
    send_block(msg[1]);
    send_block(msg[2]);
    wait_idle();

    // Reset during G_N aborts with no digest; a late result in IDLE is ignored.
    lat = 4;
    msg.delete(); msg.push_back(mk({8{64'h0f1e2d3c4b5a6978}}, 10'd512, 1'b1));
    model(1'b0, 3);
    base = pulse_cnt;
    start_hash(1'b0);
    send_block(msg[0]);
    n = 0;
    while (pulse_cnt < base + 3 && n < TMO) begin @(negedge clk); n++; end
    timeout_chk("reach_gn", n);
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    chk("abort_busy", 512'(busy_o), 512'd0);
    chk("abort_ready", 512'(blk_ready_o), 512'd0);
    chk("abort_gvalid", 512'(g_valid_o), 512'd0);
    chk("abort_hvalid", 512'(hash_valid_o), 512'd0);
    chk("abort_ops", g_n_o | g_m_o | g_h_o | hash_o, 512'd0);
    rst_i = 1'b0;
    inj_req++;
    repeat (4) @(negedge clk);
    chk("late_result_idle", 512'(busy_o), 512'd0);
    lat = 1;
    msg.delete(); msg.push_back(mk({16{32'hdeadbeef}}, 10'd0, 1'b1));
    model(1'b0, 99); run_msg(1'b0);

    // Back-to-back starts; start during busy ignored.
    lat = 2;
    msg.delete(); msg.push_back(mk({16{32'h13579bdf}}, 10'd64, 1'b1));
    model(1'b1, 99);
    start_hash(1'b1);
    send_block(msg[0]);
    start_i = 1'b1; mode256_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    msg.delete(); msg.push_back(mk({16{32'h2468ace0}}, 10'd511, 1'b1));
    model(1'b0, 99);
    n = 0;
    while (!hash_valid_o && n < TMO) begin @(negedge clk); n++; end
    timeout_chk("b2b_first", n);
    start_hash(1'b0);
    send_block(msg[0]);
    wait_idle();

    repeat (6) @(negedge clk);
    chk("req_queue_empty", 512'(exp_req_q.size()), 512'd0);
    chk("hash_queue_empty", 512'(exp_hash_q.size()), 512'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
